// File: rtl/collision_pkg.sv
// collision_pkg: shared types and default geometry for the collision probe.
package collision_pkg;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [2:0] {ST_IDLE, ST_CALC, ST_PROBE, ST_WAIT, ST_RESP} probe_state_t;
    localparam int DEF_MAP_W   = 320;
    localparam int DEF_MAP_H   = 240;
    localparam int DEF_SPR_W   = 16;
    localparam int DEF_SPR_H   = 16;
    localparam int NUM_CORNERS = 4;
    localparam int CORNER_W    = $clog2(NUM_CORNERS);
endpackage

// File: rtl/coll_addr_gen.sv
// coll_addr_gen: maps a pixel coordinate to a collision RAM address.
// A 320-wide map uses a shift-add (256+64); other widths fall back to a multiply.
module coll_addr_gen
    import collision_pkg::*;
#(
    parameter int MAP_W  = DEF_MAP_W,
    parameter int ADDR_W = 17
) (
    input  logic [9:0]        i_cx,
    input  logic [9:0]        i_cy,
    output logic [ADDR_W-1:0] o_addr
);
    generate
        if (MAP_W == 320) begin : g_shift
            assign o_addr = (ADDR_W'(i_cy) << 8) + (ADDR_W'(i_cy) << 6) + ADDR_W'(i_cx);
        end else begin : g_mul
            assign o_addr = ADDR_W'(i_cy) * ADDR_W'(MAP_W) + ADDR_W'(i_cx);
        end
    endgenerate
endmodule

// File: rtl/collision_probe.sv
// collision_probe: checks the four footprint corners of a requested move against the collision RAM.
// Optional COLLISION_PROBE_EARLY_EXIT_EN stops probing at the first blocked corner.
module collision_probe
    import collision_pkg::*;
#(
    parameter int MAP_W  = DEF_MAP_W,
    parameter int MAP_H  = DEF_MAP_H,
    parameter int SPR_W  = DEF_SPR_W,
    parameter int SPR_H  = DEF_SPR_H,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    input  logic [1:0]        req_dir,
    input  logic [3:0]        req_step,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_blocked,
    output logic [9:0]        resp_x,
    output logic [9:0]        resp_y
);
    localparam logic [CORNER_W-1:0] LAST_K = CORNER_W'(NUM_CORNERS - 1);

    probe_state_t        r_state;
    dir_t                r_dir;
    logic [9:0]          r_x, r_y, r_tx, r_ty;
    logic [3:0]          r_step;
    logic [CORNER_W-1:0] r_k;
    logic                r_hit;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_resp_valid, r_resp_blocked;
    logic [9:0]          r_resp_x, r_resp_y;

    logic [11:0]         w_tx, w_ty;
    logic                w_oob;
    logic [9:0]          w_bx, w_by, w_cx, w_cy;
    logic [CORNER_W-1:0] w_k;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_hit_now, w_hit, w_exit;

    // 12-bit arithmetic so underflow shows up as bit 11 and overflow stays positive
    assign w_tx = (r_dir == DIR_RIGHT) ? {2'b00, r_x} + {8'h00, r_step} :
                  (r_dir == DIR_LEFT)  ? {2'b00, r_x} - {8'h00, r_step} : {2'b00, r_x};
    assign w_ty = (r_dir == DIR_DOWN)  ? {2'b00, r_y} + {8'h00, r_step} :
                  (r_dir == DIR_UP)    ? {2'b00, r_y} - {8'h00, r_step} : {2'b00, r_y};
    assign w_oob = w_tx[11] || w_ty[11] ||
                   (w_tx > 12'(MAP_W - SPR_W)) || (w_ty > 12'(MAP_H - SPR_H));

    // CALC issues corner 0 from the fresh target; PROBE issues the next corner
    assign w_k  = (r_state == ST_CALC) ? '0 : r_k + CORNER_W'(1);
    assign w_bx = (r_state == ST_CALC) ? w_tx[9:0] : r_tx;
    assign w_by = (r_state == ST_CALC) ? w_ty[9:0] : r_ty;
    assign w_cx = w_bx + (w_k[0] ? 10'(SPR_W - 1) : 10'd0);
    assign w_cy = w_by + (w_k[1] ? 10'(SPR_H - 1) : 10'd0);

    coll_addr_gen #(.MAP_W(MAP_W), .ADDR_W(ADDR_W)) u_addr (
        .i_cx   (w_cx),
        .i_cy   (w_cy),
        .o_addr (w_addr)
    );

    // rd_data during PROBE k=0 belongs to no corner of this request
    assign w_hit_now = (|rd_data) && ((r_state == ST_PROBE && r_k != '0) || r_state == ST_WAIT);
    assign w_hit     = r_hit || w_hit_now;
`ifdef COLLISION_PROBE_EARLY_EXIT_EN
    assign w_exit = (r_state == ST_PROBE) && w_hit_now;
`else
    assign w_exit = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= ST_IDLE;
            r_dir          <= DIR_UP;
            r_x            <= '0;
            r_y            <= '0;
            r_tx           <= '0;
            r_ty           <= '0;
            r_step         <= '0;
            r_k            <= '0;
            r_hit          <= 1'b0;
            r_rd_addr      <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_blocked <= 1'b0;
            r_resp_x       <= '0;
            r_resp_y       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_x     <= req_x;
                    r_y     <= req_y;
                    r_dir   <= dir_t'(req_dir);
                    r_step  <= req_step;
                    r_state <= ST_CALC;
                end
                ST_CALC: begin
                    r_tx  <= w_tx[9:0];
                    r_ty  <= w_ty[9:0];
                    r_k   <= '0;
                    r_hit <= 1'b0;
                    if (w_oob) begin
                        r_state        <= ST_RESP;
                        r_resp_valid   <= 1'b1;
                        r_resp_blocked <= 1'b1;
                        r_resp_x       <= r_x;
                        r_resp_y       <= r_y;
                    end else begin
                        r_state   <= ST_PROBE;
                        r_rd_addr <= w_addr;
                    end
                end
                ST_PROBE: begin
                    r_hit <= w_hit;
                    if (w_exit) begin
                        r_state        <= ST_RESP;
                        r_resp_valid   <= 1'b1;
                        r_resp_blocked <= 1'b1;
                        r_resp_x       <= r_x;
                        r_resp_y       <= r_y;
                    end else if (r_k == LAST_K) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_k       <= w_k;
                        r_rd_addr <= w_addr;
                    end
                end
                ST_WAIT: begin
                    r_state        <= ST_RESP;
                    r_resp_valid   <= 1'b1;
                    r_resp_blocked <= w_hit;
                    r_resp_x       <= w_hit ? r_x : r_tx;
                    r_resp_y       <= w_hit ? r_y : r_ty;
                end
                ST_RESP: if (resp_ready) begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign rd_addr      = r_rd_addr;
    assign resp_valid   = r_resp_valid;
    assign resp_blocked = r_resp_blocked;
    assign resp_x       = r_resp_x;
    assign resp_y       = r_resp_y;
endmodule

// File: tb/tb_collision_probe.sv
// tb_collision_probe: directed checks of collision_probe against a modelled collision RAM.
module tb_collision_probe;
`ifdef COLLISION_PROBE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_blocked;
    logic [9:0]  req_x, req_y, resp_x, resp_y;
    logic [1:0]  req_dir;
    logic [3:0]  req_step;
    logic [16:0] rd_addr;
    logic [3:0]  rd_data = 4'h0;
    logic [3:0]  mem [0:131071];
    logic [16:0] addr_log [0:31];
    logic        rdy_seen, stale;
    int          checks = 0;
    int          errors = 0;
    int          lat;

    collision_probe dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_dir(req_dir), .req_step(req_step),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_blocked(resp_blocked), .resp_x(resp_x), .resp_y(resp_y)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // caller is at a negedge; returns at the negedge of T1
    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_x = x;
        req_y = y;
        req_dir = d;
        req_step = s;
        chk("req_ready_T0", {31'd0, req_ready}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
    endtask

    task automatic run(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d, input logic [3:0] s);
        send(x, y, d, s);
        lat = 99;
        rdy_seen = 1'b0;
        for (int t = 1; t < 20; t++) begin
            addr_log[t] = rd_addr;
            if (req_ready) rdy_seen = 1'b1;
            if (resp_valid) begin
                lat = t;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic drain();
        @(negedge Clk);
        chk("drain_valid", {31'd0, resp_valid}, 32'd0);
        chk("drain_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic resp(input string tag, input int e_lat, input logic e_blk, input int e_x, input int e_y);
        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_blk"}, {31'd0, resp_blocked}, {31'd0, e_blk});
        chk({tag, "_x"}, {22'd0, resp_x}, e_x);
        chk({tag, "_y"}, {22'd0, resp_y}, e_y);
        chk({tag, "_busy"}, {31'd0, rdy_seen}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 4'h0;
        req_valid = 1'b0;
        req_x = '0;
        req_y = '0;
        req_dir = '0;
        req_step = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_blocked", {31'd0, resp_blocked}, 32'd0);
        chk("rst_x", {22'd0, resp_x}, 32'd0);
        chk("rst_y", {22'd0, resp_y}, 32'd0);
        chk("rst_addr", {15'd0, rd_addr}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        run(100, 100, 2'd3, 4'd4);
        resp("free", 7, 1'b0, 104, 100);
        chk("free_a0", {15'd0, addr_log[2]}, 32104);
        chk("free_a1", {15'd0, addr_log[3]}, 32119);
        chk("free_a2", {15'd0, addr_log[4]}, 36904);
        chk("free_a3", {15'd0, addr_log[5]}, 36919);
        drain();
        mem[36919] = 4'h1;
        run(100, 100, 2'd3, 4'd4);
        resp("corner3", 7, 1'b1, 100, 100);
        drain();
        mem[36919] = 4'h0;
        mem[32119] = 4'h3;
        run(100, 100, 2'd3, 4'd4);
        resp("corner1", EARLY ? 5 : 7, 1'b1, 100, 100);
        drain();
        mem[32119] = 4'h0;
        mem[32104] = 4'h1;
        run(100, 100, 2'd3, 4'd4);
        resp("corner0", EARLY ? 4 : 7, 1'b1, 100, 100);
        drain();
        mem[32104] = 4'h0;
        run(304, 50, 2'd3, 4'd1);
        resp("edge_out", 2, 1'b1, 304, 50);
        chk("edge_out_hold", {15'd0, addr_log[2]}, EARLY ? 32119 : 36919);
        drain();
        run(303, 50, 2'd3, 4'd1);
        resp("edge_in", 7, 1'b0, 304, 50);
        chk("edge_in_a0", {15'd0, addr_log[2]}, 16304);
        chk("edge_in_a3", {15'd0, addr_log[5]}, 21119);
        drain();
        run(2, 0, 2'd0, 4'd4);
        resp("under_y", 2, 1'b1, 2, 0);
        drain();
        run(0, 0, 2'd2, 4'd1);
        resp("under_x", 2, 1'b1, 0, 0);
        drain();
        mem[6410] = 4'h2;
        run(10, 20, 2'd2, 4'd0);
        resp("step0_blk", EARLY ? 4 : 7, 1'b1, 10, 20);
        drain();
        mem[6410] = 4'h0;
        run(10, 20, 2'd2, 4'd0);
        resp("step0_free", 7, 1'b0, 10, 20);
        chk("step0_a0", {15'd0, addr_log[2]}, 6410);
        drain();
        run(50, 220, 2'd1, 4'd4);
        resp("bottom", 7, 1'b0, 50, 224);
        chk("bottom_a3", {15'd0, addr_log[5]}, 76545);
        drain();
        resp_ready = 1'b0;
        run(100, 100, 2'd3, 4'd4);
        resp("bp", 7, 1'b0, 104, 100);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_x", {22'd0, resp_x}, 32'd104);
            chk("bp_blk", {31'd0, resp_blocked}, 32'd0);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        drain();
        run(100, 100, 2'd1, 4'd2);
        resp("b2b", 7, 1'b0, 100, 102);
        drain();
        mem[36919] = 4'h1;
        send(100, 100, 2'd3, 4'd4);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_addr", {15'd0, rd_addr}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (resp_valid) stale = 1'b1;
        end
        chk("midrst_stale", {31'd0, stale}, 32'd0);
        run(100, 100, 2'd3, 4'd4);
        resp("after_rst", 7, 1'b1, 100, 100);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/collision_probe.md
Name: collision_probe

Overview:
- Read-side client of the synchronous collision map RAM.
- Accepts a player move request (current x/y, direction, step size) and computes the target position.
- Reads the four footprint corners of the target position from the collision RAM, one address per cycle, with 1-cycle read latency.
- Returns blocked/allowed plus the resulting position; sits between the player movement FSM and the collision RAM read port.

Parameters:
- MAP_W, 320, map width in pixels.
- MAP_H, 240, map height in pixels.
- SPR_W, 16, footprint width in pixels.
- SPR_H, 16, footprint height in pixels.
- ADDR_W, 17, collision RAM read address width.
- DATA_W, 4, collision RAM data width.

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  move request present.
- req_ready  out  1  block idle, able to accept a request.
- req_x  in  10  current x (top-left corner of footprint).
- req_y  in  10  current y (top-left corner of footprint).
- req_dir  in  2  direction: 0 up, 1 down, 2 left, 3 right.
- req_step  in  4  step in pixels; 0 is legal.
- rd_addr  out  ADDR_W  collision RAM read_address.
- rd_data  in  DATA_W  collision RAM data_Out; valid 1 cycle after rd_addr.
- resp_valid  out  1  result valid; held until accepted.
- resp_ready  in  1  consumer accepts result.
- resp_blocked  out  1  1 = move refused.
- resp_x  out  10  target x if allowed, else req_x.
- resp_y  out  10  target y if allowed, else req_y.

Behaviour:
- Reset (async assert, sync deassert):
  - FSM goes to IDLE.
  - req_ready=1 after reset; resp_valid=0, resp_blocked=0, resp_x=0, resp_y=0, rd_addr=0.
  - Reset mid-operation aborts with no response.
- Request handshake:
  - Accept on req_valid&&req_ready; this cycle is T0.
  - req_x, req_y, req_dir and req_step are registered at T0.
  - req_ready=1 only in IDLE.
- FSM states: IDLE, CALC, PROBE, WAIT, RESP.
  - IDLE -> CALC on accept.
  - CALC (T1): target = req ± step in 11-bit signed.
  - CALC -> RESP with blocked=1 if out of bounds: tx<0, ty<0, tx+SPR_W>MAP_W, or ty+SPR_H>MAP_H. No RAM reads are issued.
  - CALC -> PROBE otherwise.
  - PROBE (T2..T5): corner index k=0..3 drives rd_addr = cy*MAP_W+cx.
  - Corner order: (tx,ty), (tx+SPR_W-1,ty), (tx,ty+SPR_H-1), (tx+SPR_W-1,ty+SPR_H-1).
  - WAIT (T6): captures the final rd_data.
  - Hit accumulator: in the cycles T3..T6, hit |= (rd_data != 0).
  - RESP: resp_valid=1 from T7 (in-bounds) or T2 (out-of-bounds).
  - resp_blocked = hit or out-of-bounds.
  - RESP -> IDLE on resp_ready. Outputs hold stable while resp_valid && !resp_ready.
- Arithmetic:
  - Address computed as (cy<<8)+(cy<<6)+cx when MAP_W=320; generic multiply otherwise.
  - Result truncated to ADDR_W.
- Boundaries:
  - step=0 is still probed; the result reflects the current tile.
  - Target exactly touching an edge (tx+SPR_W==MAP_W) is in bounds.
  - rd_addr holds its last value outside PROBE.
- resp_valid and req_ready are never high together; back-to-back requests are separated by at least one IDLE cycle.

Optional Feature:
- Macro: COLLISION_PROBE_EARLY_EXIT_EN.
- Defined:
  - The first returned rd_data!=0 ends probing; remaining corners are skipped.
  - FSM goes directly to RESP on the cycle after that data is observed.
  - Latency becomes variable. Example: corner 0 blocked gives resp_valid at T4.
- Undefined: all four corners are always probed; fixed latency T7.

Decomposition:
- Package collision_pkg:
  - dir_t enum (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT).
  - probe_state_t enum.
  - Default MAP_W/MAP_H/SPR_W/SPR_H localparams.
  - NUM_CORNERS=4.
- Sub-module coll_addr_gen:
  - Combinational (cx,cy) -> rd_addr.
  - Holds the shift-add/multiply selection.

Test Plan:
- Free move: map all zeros, req (100,100,right,4) -> resp_valid at T7, blocked=0, resp=(104,100). rd_addr sequence is 32104, 32119, 36904, 36919.
- Blocked corner: map[36919]=1, same req -> blocked=1, resp=(100,100). Early-exit build: same response at T7. Map[32104]=1 in early-exit build -> resp at T4.
- Edge bounds: req (304,50,right,1) -> blocked=1 at T2 with no PROBE cycles. Req (303,50,right,1) -> probed, blocked=0, resp=(304,50).
- Underflow: req (2,0,up,4) -> ty=-4, blocked=1 at T2, resp=(2,0).
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_* stable and req_ready=0 throughout; accept on release; next request accepted the following cycle.
- Reset mid-probe: assert Reset_n=0 at T4 -> immediately resp_valid=0, req_ready=1 after release, no stale response; a new request yields a correct result.
